// File: rtl/popcount.sv
// Population count of a small bit vector; used to turn a lane-valid mask into a lane count.
module popcount #(
    parameter int unsigned WIDTH = 2
) (
    input  logic [WIDTH-1:0]           i_bits,
    output logic [$clog2(WIDTH+1)-1:0] o_count
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_count = o_count + CW'(i_bits[i]);
        end
    end

endmodule

// File: rtl/fetch_pair_queue.sv
// Two-wide in-order instruction queue between fetch and decode.
// Compacts a 0-2 lane enqueue mask and presents the two oldest entries to decode.
module fetch_pair_queue #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_flush,
    input  logic [1:0]                    i_enq_valid,
    input  logic [2*DATA_WIDTH-1:0]       i_enq_data,
    output logic                          o_enq_ready,
    output logic [1:0]                    o_deq_valid,
    output logic [2*DATA_WIDTH-1:0]       o_deq_data,
    input  logic [1:0]                    i_deq_ack,
    output logic [$clog2(DEPTH+1)-1:0]    o_count
);

    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic [1:0]    r_hold_mask;
    logic          r_hold_pending;

    logic [1:0]    w_pop;
    logic [1:0]    w_enq_n;
    logic [1:0]    w_deq_n;
    logic [CW-1:0] w_space;
    logic [CW-1:0] w_count_next;
    logic [AW-1:0] w_head1;
    logic [AW-1:0] w_tail1;
    logic [DW-1:0] w_lane0;
    logic [DW-1:0] w_lane1;
    logic [DW-1:0] w_wr0_data;

    popcount #(
        .WIDTH (2)
    ) u_popcount (
        .i_bits  (i_enq_valid),
        .o_count (w_pop)
    );

    assign w_lane0 = i_enq_data[DW-1:0];
    assign w_lane1 = i_enq_data[2*DW-1:DW];
    assign w_head1 = r_head + AW'(1);
    assign w_tail1 = r_tail + AW'(1);

    // Ready looks only at registered occupancy, so it never depends on this cycle's dequeue.
    always_comb begin
        w_space     = CW'(DEPTH) - r_count;
        o_enq_ready = (w_space >= CW'(2));
        o_deq_valid = {(r_count >= CW'(2)), (r_count != '0)};
        o_deq_data  = {r_mem[w_head1], r_mem[r_head]};
        o_count     = r_count;
    end

    always_comb begin
        w_enq_n    = 2'd0;
        w_deq_n    = 2'd0;
        w_wr0_data = w_lane0;
        if (o_enq_ready && !i_flush) begin
            w_enq_n = w_pop;
        end
        // A lone lane 1 is compacted down into the tail slot.
        if (i_enq_valid == 2'b10) begin
            w_wr0_data = w_lane1;
        end
        if (i_deq_ack[0] && o_deq_valid[0]) begin
            if (i_deq_ack[1] && o_deq_valid[1]) begin
                w_deq_n = 2'd2;
            end else begin
                w_deq_n = 2'd1;
            end
        end
        w_count_next = r_count + CW'(w_enq_n) - CW'(w_deq_n);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + AW'(w_deq_n);
            r_tail  <= r_tail + AW'(w_enq_n);
            r_count <= w_count_next;
        end
    end

    // Storage carries no reset; validity is tracked by the occupancy counter alone.
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            if (w_enq_n != 2'd0) begin
                r_mem[r_tail] <= w_wr0_data;
            end
            if (w_enq_n == 2'd2) begin
                r_mem[w_tail1] <= w_lane1;
            end
        end
    end

    // Remembers a refused request so a mask change before acceptance can be flagged.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_hold_pending <= 1'b0;
            r_hold_mask    <= 2'b00;
        end else begin
            r_hold_pending <= (i_enq_valid != 2'b00) && !o_enq_ready && !i_flush;
            r_hold_mask    <= i_enq_valid;
        end
    end

    always_ff @(posedge i_clk) begin
        assert ((DEPTH & (DEPTH - 1)) == 0)
            else $error("fetch_pair_queue: DEPTH %0d is not a power of two", DEPTH);
        if (i_rst_n && !i_flush && r_hold_pending) begin
            assert (i_enq_valid == r_hold_mask)
                else $error("fetch_pair_queue: enq mask changed from %b to %b before acceptance",
                            r_hold_mask, i_enq_valid);
        end
    end

endmodule

// File: tb/tb_fetch_pair_queue.sv
// Directed bench for fetch_pair_queue: a queue-based reference model checked every cycle,
// plus hand-computed expectations at key points of each scenario.
module tb_fetch_pair_queue;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic              clk;
    logic              i_rst_n;
    logic              i_flush;
    logic [1:0]        i_enq_valid;
    logic [2*DW-1:0]   i_enq_data;
    logic              o_enq_ready;
    logic [1:0]        o_deq_valid;
    logic [2*DW-1:0]   o_deq_data;
    logic [1:0]        i_deq_ack;
    logic [CW-1:0]     o_count;

    int n_pass  = 0;
    int n_total = 0;

    logic [DW-1:0] mq[$];
    bit            model_on = 0;
    int            exp_seq;

    fetch_pair_queue #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (i_rst_n),
        .i_flush     (i_flush),
        .i_enq_valid (i_enq_valid),
        .i_enq_data  (i_enq_data),
        .o_enq_ready (o_enq_ready),
        .o_deq_valid (o_deq_valid),
        .o_deq_data  (o_deq_data),
        .i_deq_ack   (i_deq_ack),
        .o_count     (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, clock it, and advance the reference model.
    task automatic cyc(input logic rst_n, input logic flush, input logic [1:0] mask,
                       input logic [DW-1:0] d1, input logic [DW-1:0] d0, input logic [1:0] ack);
        int sz;
        bit rdy;
        i_rst_n     = rst_n;
        i_flush     = flush;
        i_enq_valid = mask;
        i_enq_data  = {d1, d0};
        i_deq_ack   = ack;
        @(posedge clk);
        sz  = mq.size();
        rdy = (int'(DEPTH) - sz) >= 2;
        if (!rst_n || flush) begin
            mq.delete();
        end else begin
            if (ack[0] && sz >= 1) begin
                void'(mq.pop_front());
                if (ack[1] && sz >= 2) void'(mq.pop_front());
            end
            if (rdy) begin
                if (mask[0]) mq.push_back(d0);
                if (mask[1]) mq.push_back(d1);
            end
        end
        model_on = 1;
        #1;
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
    endtask

    task automatic flush_q();
        cyc(1'b1, 1'b1, 2'b00, 32'h0, 32'h0, 2'b00);
    endtask

    // Record what decode takes this cycle when acknowledging both lanes.
    task automatic consume_check();
        if (o_deq_valid[0]) begin
            chk("wrap_lane0", 64'(o_deq_data[DW-1:0]), 64'(exp_seq));
            exp_seq++;
            if (o_deq_valid[1]) begin
                chk("wrap_lane1", 64'(o_deq_data[2*DW-1:DW]), 64'(exp_seq));
                exp_seq++;
            end
        end
    endtask

    // Per-cycle comparison against the reference model.
    always @(negedge clk) begin
        if (model_on) begin
            chk("mdl_count", 64'(o_count), 64'(mq.size()));
            chk("mdl_ready", 64'(o_enq_ready), 64'((int'(DEPTH) - mq.size()) >= 2));
            chk("mdl_valid", 64'(o_deq_valid), 64'({mq.size() >= 2, mq.size() >= 1}));
            if (mq.size() >= 1) chk("mdl_lane0", 64'(o_deq_data[DW-1:0]), 64'(mq[0]));
            if (mq.size() >= 2) chk("mdl_lane1", 64'(o_deq_data[2*DW-1:DW]), 64'(mq[1]));
        end
    end

    initial begin
        i_rst_n = 1'b0; i_flush = 1'b0; i_enq_valid = 2'b00; i_enq_data = '0; i_deq_ack = 2'b00;

        // Reset
        cyc(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
        cyc(1'b0, 1'b0, 2'b11, 32'h1, 32'h2, 2'b11);
        chk("rst_count", 64'(o_count), 64'd0);
        chk("rst_valid", 64'(o_deq_valid), 64'd0);
        chk("rst_ready", 64'(o_enq_ready), 64'd1);

        // Empty queue ignores acks
        cyc(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 2'b11);
        chk("empty_ack_count", 64'(o_count), 64'd0);

        // Pair enqueue {B,A}
        cyc(1'b1, 1'b0, 2'b11, 32'hB000_000B, 32'hA000_000A, 2'b00);
        chk("pair_valid", 64'(o_deq_valid), 64'h3);
        chk("pair_lane0", 64'(o_deq_data[DW-1:0]), 64'hA000_000A);
        chk("pair_lane1", 64'(o_deq_data[2*DW-1:DW]), 64'hB000_000B);
        chk("pair_count", 64'(o_count), 64'd2);

        // Compaction: lone lane 1, then lone lane 0
        flush_q();
        cyc(1'b1, 1'b0, 2'b10, 32'hC000_000C, 32'hDEAD_DEAD, 2'b00);
        cyc(1'b1, 1'b0, 2'b01, 32'hBEEF_BEEF, 32'hD000_000D, 2'b00);
        chk("cmp_count", 64'(o_count), 64'd2);
        chk("cmp_lane0", 64'(o_deq_data[DW-1:0]), 64'hC000_000C);
        chk("cmp_lane1", 64'(o_deq_data[2*DW-1:DW]), 64'hD000_000D);

        // Fill and full boundaries
        flush_q();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 2'b11, 32'h100 + 32'(2*i+1), 32'h100 + 32'(2*i), 2'b00);
            if (i == 2) begin
                chk("fill6_count", 64'(o_count), 64'd6);
                chk("fill6_ready", 64'(o_enq_ready), 64'd1);
            end
        end
        chk("fill8_count", 64'(o_count), 64'd8);
        chk("fill8_ready", 64'(o_enq_ready), 64'd0);
        cyc(1'b1, 1'b0, 2'b11, 32'h201, 32'h200, 2'b00);
        cyc(1'b1, 1'b0, 2'b11, 32'h201, 32'h200, 2'b00);
        chk("full_hold_count", 64'(o_count), 64'd8);
        cyc(1'b1, 1'b0, 2'b11, 32'h201, 32'h200, 2'b11);
        chk("full_deq_count", 64'(o_count), 64'd6);
        cyc(1'b1, 1'b0, 2'b11, 32'h201, 32'h200, 2'b00);
        chk("full_refill_count", 64'(o_count), 64'd8);
        cyc(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 2'b01);
        chk("c7_count", 64'(o_count), 64'd7);
        chk("c7_ready", 64'(o_enq_ready), 64'd0);
        cyc(1'b1, 1'b0, 2'b01, 32'h0, 32'h300, 2'b00);
        chk("c7_single_refused", 64'(o_count), 64'd7);
        cyc(1'b1, 1'b0, 2'b01, 32'h0, 32'h300, 2'b01);
        chk("c7_deq_count", 64'(o_count), 64'd6);
        cyc(1'b1, 1'b0, 2'b01, 32'h0, 32'h300, 2'b00);
        chk("c7_accept_count", 64'(o_count), 64'd7);
        idle();

        // Ack patterns at occupancy 3
        flush_q();
        cyc(1'b1, 1'b0, 2'b11, 32'hE1, 32'hE0, 2'b00);
        cyc(1'b1, 1'b0, 2'b01, 32'h0, 32'hE2, 2'b00);
        cyc(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 2'b10);
        chk("ack10_count", 64'(o_count), 64'd3);
        cyc(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 2'b01);
        chk("ack01_count", 64'(o_count), 64'd2);
        chk("ack01_head", 64'(o_deq_data[DW-1:0]), 64'hE1);
        cyc(1'b1, 1'b0, 2'b01, 32'h0, 32'hE3, 2'b00);
        cyc(1'b1, 1'b0, 2'b11, 32'hE5, 32'hE4, 2'b11);
        chk("ack11_enq_count", 64'(o_count), 64'd3);
        chk("ack11_head", 64'(o_deq_data[DW-1:0]), 64'hE3);

        // Wrap-around streaming 0..39
        flush_q();
        exp_seq = 0;
        for (int i = 0; i < 20; i++) begin
            consume_check();
            cyc(1'b1, 1'b0, 2'b11, 32'(2*i+1), 32'(2*i), 2'b11);
            chk("wrap_count", 64'(o_count), 64'd2);
        end
        consume_check();
        cyc(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 2'b11);
        chk("wrap_total", 64'(exp_seq), 64'd40);
        chk("wrap_drain_count", 64'(o_count), 64'd0);

        // Flush at occupancy 5 with enqueue and dequeue pending
        cyc(1'b1, 1'b0, 2'b11, 32'hF1, 32'hF0, 2'b00);
        cyc(1'b1, 1'b0, 2'b11, 32'hF3, 32'hF2, 2'b00);
        cyc(1'b1, 1'b0, 2'b01, 32'h0, 32'hF4, 2'b00);
        chk("pre_flush_count", 64'(o_count), 64'd5);
        cyc(1'b1, 1'b1, 2'b11, 32'hF6, 32'hF5, 2'b11);
        chk("flush_count", 64'(o_count), 64'd0);
        chk("flush_valid", 64'(o_deq_valid), 64'd0);
        chk("flush_ready", 64'(o_enq_ready), 64'd1);

        // Mid-operation reset behaves the same
        cyc(1'b1, 1'b0, 2'b11, 32'hA1, 32'hA0, 2'b00);
        cyc(1'b1, 1'b0, 2'b11, 32'hA3, 32'hA2, 2'b00);
        cyc(1'b1, 1'b0, 2'b01, 32'h0, 32'hA4, 2'b00);
        cyc(1'b0, 1'b0, 2'b11, 32'hA6, 32'hA5, 2'b11);
        chk("mrst_count", 64'(o_count), 64'd0);
        chk("mrst_valid", 64'(o_deq_valid), 64'd0);
        chk("mrst_ready", 64'(o_enq_ready), 64'd1);

        // Reset together with flush, then a fresh entry after it
        cyc(1'b0, 1'b1, 2'b11, 32'h0, 32'h0, 2'b00);
        cyc(1'b1, 1'b0, 2'b01, 32'h0, 32'h5A5A_5A5A, 2'b00);
        chk("post_rst_count", 64'(o_count), 64'd1);
        chk("post_rst_valid", 64'(o_deq_valid), 64'd1);
        chk("post_rst_lane0", 64'(o_deq_data[DW-1:0]), 64'h5A5A_5A5A);
        idle();

        model_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
